// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   INSTR_WIDTH      - instruction word width
//   PC_INC           - byte distance between consecutive instructions
//   FETCH_ADDR_WIDTH - width of the pc field carried with each buffered word;
//                      keep equal to the fetch_unit ADDR_WIDTH parameter
//   fetch_entry_t    - {pc, instr} pair held in the prefetch FIFO
package fetch_pkg;

    localparam int INSTR_WIDTH      = 16;
    localparam int PC_INC           = 2;
    localparam int FETCH_ADDR_WIDTH = 16;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch_entry_t.
//   clk, rst     - clock, asynchronous active-low reset
//   push, entry  - write entry at the tail
//   pop          - drop the head entry
//   flush        - empty the FIFO; overrides push and pop
//   count        - number of buffered entries (0..DEPTH)
//   head         - head entry, all zeros when empty
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               entry,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pop_eff;
    logic            push_eff;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop_eff  = pop && (count != '0) && !flush;
    assign push_eff = push && ((count != FULL) || pop_eff) && !flush;

    // Storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_eff && !pop_eff) begin
                count <= count + CW'(1);
            end else if (pop_eff && !push_eff) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator for a combinational-read
// instruction memory, with a prefetch FIFO feeding decode.
//   clk, rst                      - clock, asynchronous active-low reset
//   mem_addr, mem_enable          - read request to instruction memory
//   mem_wr, mem_data_in           - write port, tied off
//   mem_data_out                  - read data, same cycle as the request
//   instr_valid, instr, instr_pc  - FIFO head towards decode
//   instr_ready                   - decode accepts the head
//   redirect, redirect_pc         - flush and restart fetch at redirect_pc
//   halt                          - stop issuing fetches, keep draining
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_enable,
    output logic                   mem_wr,
    output logic [INSTR_WIDTH-1:0] mem_data_in,
    input  logic [INSTR_WIDTH-1:0] mem_data_out,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   halt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [CW-1:0]         count;
    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;
    logic                  pop;
    logic                  fetch;

    assign pop   = instr_valid && instr_ready;
    // rst gates fetch so mem_enable drops as soon as reset is asserted.
    assign fetch = !redirect && !halt && rst && ((count != FULL) || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= redirect_pc & ~ADDR_WIDTH'(1);
        end else if (fetch) begin
            pc_q <= pc_q + ADDR_WIDTH'(PC_INC);
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = FETCH_ADDR_WIDTH'(pc_q);
        push_entry.instr = mem_data_out;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch),
        .pop   (pop && !redirect),
        .flush (redirect),
        .entry (push_entry),
        .count (count),
        .head  (head_entry)
    );

    assign mem_addr    = pc_q;
    assign mem_enable  = fetch;
    assign mem_wr      = 1'b0;
    assign mem_data_in = '0;

    assign instr_valid = (count != '0);
    assign instr       = head_entry.instr;
    assign instr_pc    = ADDR_WIDTH'(head_entry.pc);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;

    logic [15:0] w_mem_addr;
    logic        w_mem_enable;
    logic        w_mem_wr;
    logic [15:0] w_mem_data_in;
    logic [15:0] w_mem_data_out;
    logic        w_instr_valid;
    logic [15:0] w_instr;
    logic [15:0] w_instr_pc;

    logic [15:0] imem [0:32767];

    exp_t        exp_q [$];
    logic [15:0] pc_m;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    assign mem_data_out   = imem[mem_addr[15:1]];
    assign w_mem_data_out = imem[w_mem_addr[15:1]];

    fetch_unit #(.ADDR_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt)
    );

    fetch_unit #(.ADDR_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFC)) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (w_mem_addr),
        .mem_enable   (w_mem_enable),
        .mem_wr       (w_mem_wr),
        .mem_data_in  (w_mem_data_in),
        .mem_data_out (w_mem_data_out),
        .instr_valid  (w_instr_valid),
        .instr        (w_instr),
        .instr_pc     (w_instr_pc),
        .instr_ready  (1'b1),
        .redirect     (1'b0),
        .redirect_pc  (16'h0000),
        .halt         (1'b0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares the head against the scoreboard and pops on handshake.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("instr", 32'(instr), 32'(exp_q[0].instr));
                chk("instr_pc", 32'(instr_pc), 32'(exp_q[0].pc));
                if (instr_ready && !redirect) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("instr_empty", 32'(instr), 32'h0);
                chk("instr_pc_empty", 32'(instr_pc), 32'h0);
            end
        end
    end

    // Driver: applies one cycle of inputs and predicts the fetch for that cycle.
    task automatic cycle(input logic rdy, input logic rd, input logic [15:0] rpc, input logic hl);
        bit fetch_m;
        @(negedge clk);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        #2;
        fetch_m = !rd && !hl && (exp_q.size() < DEPTH);
        chk("mem_enable", 32'(mem_enable), 32'(fetch_m));
        chk("mem_addr", 32'(mem_addr), 32'(pc_m));
        if (rd) begin
            exp_q.delete();
            pc_m = {rpc[15:1], 1'b0};
        end else if (fetch_m) begin
            exp_q.push_back({pc_m, imem[pc_m[15:1]]});
            pc_m = pc_m + 16'd2;
        end
    endtask

    // Wrap-around instance: first four delivered pcs after the first release.
    initial begin
        logic [15:0] wexp [4];
        logic [15:0] e;
        int got;
        wexp[0] = 16'hFFFC;
        wexp[1] = 16'hFFFE;
        wexp[2] = 16'h0000;
        wexp[3] = 16'h0002;
        got = 0;
        @(posedge rst);
        for (int c = 0; c < 12 && got < 4; c++) begin
            @(negedge clk);
            #1;
            if (w_instr_valid) begin
                e = wexp[got];
                chk("wrap_pc", 32'(w_instr_pc), 32'(e));
                chk("wrap_instr", 32'(w_instr), 32'(imem[e[15:1]]));
                got++;
            end
        end
        if (got < 4) chk("wrap_timeout", 32'(got), 32'd4);
    end

    initial begin
        bit hl_r;
        rst         = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        for (int i = 0; i < 32768; i++) imem[i] = 16'($urandom);
        imem[0] = 16'h1111;
        imem[1] = 16'h2222;
        imem[2] = 16'h3333;
        pc_m = 16'h0000;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_mem_enable", 32'(mem_enable), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_data_in", 32'(mem_data_in), 32'h0);
        chk("rst_wrap_addr", 32'(w_mem_addr), 32'hFFFC);
        chk("rst_wrap_enable", 32'(w_mem_enable), 32'h0);

        @(posedge clk);
        #1 rst = 1'b1;

        repeat (6) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        repeat (6) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0041, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        cycle(1'b1, 1'b1, 16'h0100, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b1, 16'h0200, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        hl_r = 1'b0;
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) hl_r = ~hl_r;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  16'($urandom), hl_r);
        end

        repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_instr_valid", 32'(instr_valid), 32'h0);
        chk("midrst_mem_enable", 32'(mem_enable), 32'h0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
        exp_q.delete();
        pc_m = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
